// File: rtl/pacoblaze_alu_sequencer_if.sv
// Instruction handshake between the fetch/control path (master) and the ALU sequencer (slave).
interface pacoblaze_alu_sequencer_if;
    logic        instr_valid;
    logic [17:0] instr;
    logic        instr_ready;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/pacoblaze_alu_sequencer.sv
// Two-cycle KCPSM3 ALU front-end: decodes arithmetic/logic/shift instructions, feeds the
// combinational ALU from a 16x8 register file and retires result, Z and C.
module pacoblaze_alu_sequencer #(
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned REG_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    pacoblaze_alu_sequencer_if.slave ibus,
    output logic [3:0]               alu_operation,
    output logic [2:0]               alu_shift_operation,
    output logic                     alu_shift_direction,
    output logic                     alu_shift_constant,
    output logic [REG_WIDTH-1:0]     alu_operand_a,
    output logic [REG_WIDTH-1:0]     alu_operand_b,
    output logic                     alu_carry_in,
    input  logic [REG_WIDTH-1:0]     alu_result,
    input  logic                     alu_zero,
    input  logic                     alu_carry,
    output logic                     flag_zero,
    output logic                     flag_carry,
    input  logic                     flags_save,
    input  logic                     flags_restore,
    output logic                     illegal,
    output logic                     done,
    input  logic [3:0]               rf_addr,
    output logic [REG_WIDTH-1:0]     rf_data
);

    // ALU main-operation encoding seen on alu_operation
    typedef enum logic [3:0] {
        OP_LOAD    = 4'd0,
        OP_AND     = 4'd1,
        OP_OR      = 4'd2,
        OP_XOR     = 4'd3,
        OP_TEST    = 4'd4,
        OP_COMPARE = 4'd5,
        OP_ADD     = 4'd6,
        OP_ADDCY   = 4'd7,
        OP_SUB     = 4'd8,
        OP_SUBCY   = 4'd9,
        OP_SHIFT   = 4'd10
    } alu_op_e;

    typedef enum logic {S_IDLE, S_EXEC} state_e;
    typedef enum logic [1:0] {FL_NONE, FL_ZC, FL_Z_CLR} flag_mode_e;

    state_e                 r_state;
    alu_op_e                r_alu_op;
    flag_mode_e             r_flag_mode;
    logic                   r_wr;
    logic [3:0]             r_dst;
    logic [REG_WIDTH-1:0]   r_op_a;
    logic [REG_WIDTH-1:0]   r_op_b;
    logic [2:0]             r_shift_op;
    logic                   r_shift_dir;
    logic                   r_shift_const;
    logic                   r_done;
    logic                   r_illegal;
    logic                   r_z;
    logic                   r_c;
    logic                   r_sh_z;
    logic                   r_sh_c;
    logic [REG_WIDTH-1:0]   r_regs [NUM_REGS];

    logic [5:0]             w_opcode;
    logic [3:0]             w_nibble;
    alu_op_e                w_op;
    flag_mode_e             w_fl;
    logic                   w_wr;
    logic                   w_legal;
    logic                   w_shift_ok;
    logic [REG_WIDTH-1:0]   w_src_a;
    logic [REG_WIDTH-1:0]   w_src_b;
    logic                   w_z_next;
    logic                   w_c_next;

    assign w_opcode = ibus.instr[17:12];
    assign w_nibble = ibus.instr[3:0];
    assign w_src_a  = r_regs[ibus.instr[11:8]];
    assign w_src_b  = w_opcode[0] ? r_regs[ibus.instr[7:4]] : ibus.instr[7:0];

    always_comb begin
        w_shift_ok = 1'b0;
        case (w_nibble)
            4'h0, 4'h2, 4'h4, 4'h6, 4'h7, 4'h8, 4'hA, 4'hC, 4'hE, 4'hF: w_shift_ok = 1'b1;
            default: w_shift_ok = 1'b0;
        endcase

        w_op    = OP_LOAD;
        w_fl    = FL_NONE;
        w_wr    = 1'b0;
        w_legal = 1'b1;
        case (w_opcode[5:1])
            5'h00: w_wr = 1'b1;
            5'h05: begin w_op = OP_AND;     w_fl = FL_Z_CLR; w_wr = 1'b1; end
            5'h06: begin w_op = OP_OR;      w_fl = FL_Z_CLR; w_wr = 1'b1; end
            5'h07: begin w_op = OP_XOR;     w_fl = FL_Z_CLR; w_wr = 1'b1; end
            5'h09: begin w_op = OP_TEST;    w_fl = FL_ZC; end
            5'h0A: begin w_op = OP_COMPARE; w_fl = FL_ZC; end
            5'h0C: begin w_op = OP_ADD;     w_fl = FL_ZC;    w_wr = 1'b1; end
            5'h0D: begin w_op = OP_ADDCY;   w_fl = FL_ZC;    w_wr = 1'b1; end
            5'h0E: begin w_op = OP_SUB;     w_fl = FL_ZC;    w_wr = 1'b1; end
            5'h0F: begin w_op = OP_SUBCY;   w_fl = FL_ZC;    w_wr = 1'b1; end
            5'h10: begin
                if (!w_opcode[0] && w_shift_ok) begin
                    w_op = OP_SHIFT;
                    w_fl = FL_ZC;
                    w_wr = 1'b1;
                end else begin
                    w_legal = 1'b0;
                end
            end
            default: w_legal = 1'b0;
        endcase
    end

    // A restore strobe wins over the EXEC flag update; save always sees pre-update flags.
    always_comb begin
        w_z_next = r_z;
        w_c_next = r_c;
        if (r_state == S_EXEC) begin
            case (r_flag_mode)
                FL_ZC:    begin w_z_next = alu_zero; w_c_next = alu_carry; end
                FL_Z_CLR: begin w_z_next = alu_zero; w_c_next = 1'b0;      end
                default:  ;
            endcase
        end
        if (flags_restore) begin
            w_z_next = r_sh_z;
            w_c_next = r_sh_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_alu_op      <= OP_LOAD;
            r_flag_mode   <= FL_NONE;
            r_wr          <= 1'b0;
            r_dst         <= '0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_shift_op    <= '0;
            r_shift_dir   <= 1'b0;
            r_shift_const <= 1'b0;
            r_done        <= 1'b0;
            r_illegal     <= 1'b0;
            r_z           <= 1'b0;
            r_c           <= 1'b0;
            r_sh_z        <= 1'b0;
            r_sh_c        <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_z <= w_z_next;
            r_c <= w_c_next;
            if (flags_save) begin
                r_sh_z <= r_z;
                r_sh_c <= r_c;
            end
            if (r_state == S_IDLE) begin
                if (ibus.instr_valid) begin
                    r_state       <= S_EXEC;
                    r_done        <= 1'b1;
                    r_illegal     <= !w_legal;
                    r_wr          <= w_wr;
                    r_flag_mode   <= w_fl;
                    r_alu_op      <= w_op;
                    r_dst         <= ibus.instr[11:8];
                    r_op_a        <= w_src_a;
                    r_op_b        <= w_src_b;
                    r_shift_op    <= {1'b0, ibus.instr[2:1]};
                    r_shift_dir   <= ibus.instr[3];
                    r_shift_const <= ibus.instr[0];
                end
            end else begin
                r_state   <= S_IDLE;
                r_done    <= 1'b0;
                r_illegal <= 1'b0;
                if (r_wr) begin
                    r_regs[r_dst] <= (r_alu_op == OP_LOAD) ? r_op_b : alu_result;
                end
            end
        end
    end

    assign ibus.instr_ready    = reset_n && (r_state == S_IDLE);
    assign alu_operation       = r_alu_op;
    assign alu_shift_operation = r_shift_op;
    assign alu_shift_direction = r_shift_dir;
    assign alu_shift_constant  = r_shift_const;
    assign alu_operand_a       = r_op_a;
    assign alu_operand_b       = r_op_b;
    assign alu_carry_in        = r_c;
    assign flag_zero           = r_z;
    assign flag_carry          = r_c;
    assign illegal             = r_illegal;
    assign done                = r_done;
    assign rf_data             = r_regs[rf_addr];

endmodule

// File: tb/tb_pacoblaze_alu_sequencer.sv
// Scoreboard bench for pacoblaze_alu_sequencer: instruction-level reference model, behavioural
// ALU on the alu_* ports, monitor comparing illegal/done/flags/register file after each EXEC.
module tb_pacoblaze_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] alu_operation;
    logic [2:0] alu_shift_operation;
    logic       alu_shift_direction;
    logic       alu_shift_constant;
    logic [7:0] alu_operand_a;
    logic [7:0] alu_operand_b;
    logic       alu_carry_in;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_carry;
    logic       flag_zero;
    logic       flag_carry;
    logic       flags_save;
    logic       flags_restore;
    logic       illegal;
    logic       done;
    logic [3:0] rf_addr;
    logic [7:0] rf_data;

    pacoblaze_alu_sequencer_if ibus ();

    pacoblaze_alu_sequencer #(.NUM_REGS(16), .REG_WIDTH(8)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .ibus                (ibus.slave),
        .alu_operation       (alu_operation),
        .alu_shift_operation (alu_shift_operation),
        .alu_shift_direction (alu_shift_direction),
        .alu_shift_constant  (alu_shift_constant),
        .alu_operand_a       (alu_operand_a),
        .alu_operand_b       (alu_operand_b),
        .alu_carry_in        (alu_carry_in),
        .alu_result          (alu_result),
        .alu_zero            (alu_zero),
        .alu_carry           (alu_carry),
        .flag_zero           (flag_zero),
        .flag_carry          (flag_carry),
        .flags_save          (flags_save),
        .flags_restore       (flags_restore),
        .illegal             (illegal),
        .done                (done),
        .rf_addr             (rf_addr),
        .rf_data             (rf_data)
    );

    always #50 clk = ~clk;

    // Outputs the sequencer must ignore (LOAD result, logic-op carry) are scrambled.
    logic       junk;
    logic [8:0] a_t;
    logic       sin;
    always @(posedge clk) junk <= 1'($urandom);

    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        a_t        = '0;
        sin        = 1'b0;
        case (alu_operation)
            4'd0: begin alu_result = ~alu_operand_b; alu_carry = junk; end
            4'd1: begin alu_result = alu_operand_a & alu_operand_b; alu_carry = junk; end
            4'd2: begin alu_result = alu_operand_a | alu_operand_b; alu_carry = junk; end
            4'd3: begin alu_result = alu_operand_a ^ alu_operand_b; alu_carry = junk; end
            4'd4: begin alu_result = alu_operand_a & alu_operand_b; alu_carry = ^alu_result; end
            4'd5, 4'd8: begin
                a_t = {1'b0, alu_operand_a} - {1'b0, alu_operand_b};
                alu_result = a_t[7:0]; alu_carry = a_t[8];
            end
            4'd6: begin
                a_t = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
                alu_result = a_t[7:0]; alu_carry = a_t[8];
            end
            4'd7: begin
                a_t = {1'b0, alu_operand_a} + {1'b0, alu_operand_b} + {8'd0, alu_carry_in};
                alu_result = a_t[7:0]; alu_carry = a_t[8];
            end
            4'd9: begin
                a_t = {1'b0, alu_operand_a} - {1'b0, alu_operand_b} - {8'd0, alu_carry_in};
                alu_result = a_t[7:0]; alu_carry = a_t[8];
            end
            4'd10: begin
                case (alu_shift_operation)
                    3'd0:    sin = alu_carry_in;
                    3'd1:    sin = alu_operand_a[7];
                    3'd2:    sin = alu_operand_a[0];
                    3'd3:    sin = alu_shift_constant;
                    default: sin = 1'b0;
                endcase
                if (alu_shift_direction) begin
                    alu_result = {sin, alu_operand_a[7:1]}; alu_carry = alu_operand_a[0];
                end else begin
                    alu_result = {alu_operand_a[6:0], sin}; alu_carry = alu_operand_a[7];
                end
            end
            default: ;
        endcase
        alu_zero = (alu_result == 8'd0);
    end

    typedef struct packed {
        logic            ill;
        logic            z;
        logic            c;
        logic [15:0][7:0] regs;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] m_regs [16];
    logic       m_z, m_c, m_sh_z, m_sh_c;
    int         checks   = 0;
    int         failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_z = 0; m_c = 0; m_sh_z = 0; m_sh_c = 0;
    endtask

    // Instruction-level semantics with plain integer arithmetic.
    task automatic model_step(input logic [17:0] ins, input bit sv, input bit rs);
        logic [5:0] opc;
        int   x, a, b, r, s;
        bit   wr, legal, upd, nz, nc, oz, oc;
        exp_t e;
        opc = ins[17:12];
        x   = int'(ins[11:8]);
        a   = int'(m_regs[x]);
        b   = opc[0] ? int'(m_regs[int'(ins[7:4])]) : int'(ins[7:0]);
        r = 0; wr = 0; legal = 1; upd = 1;
        oz = m_z; oc = m_c; nz = m_z; nc = m_c;
        case (opc)
            6'h00, 6'h01: begin r = b; wr = 1; upd = 0; end
            6'h0A, 6'h0B: begin r = a & b; wr = 1; nc = 0; end
            6'h0C, 6'h0D: begin r = a | b; wr = 1; nc = 0; end
            6'h0E, 6'h0F: begin r = a ^ b; wr = 1; nc = 0; end
            6'h12, 6'h13: begin r = a & b; nc = ^(8'(r)); end
            6'h14, 6'h15: begin r = (a == b) ? 0 : 1; nc = (a < b); end
            6'h18, 6'h19, 6'h1A, 6'h1B: begin
                s = a + b + ((opc[1] && m_c) ? 1 : 0);
                r = s % 256; nc = (s > 255); wr = 1;
            end
            6'h1C, 6'h1D, 6'h1E, 6'h1F: begin
                s = a - b - ((opc[1] && m_c) ? 1 : 0);
                r = (s + 512) % 256; nc = (s < 0); wr = 1;
            end
            6'h20: begin
                wr = 1;
                case (ins[3:0])
                    4'hE: begin r = a / 2;                      nc = (a % 2 == 1); end
                    4'hF: begin r = a / 2 + 128;                nc = (a % 2 == 1); end
                    4'hA: begin r = a / 2 + (a >= 128 ? 128 : 0); nc = (a % 2 == 1); end
                    4'h8: begin r = a / 2 + (m_c ? 128 : 0);    nc = (a % 2 == 1); end
                    4'hC: begin r = a / 2 + (a % 2) * 128;      nc = (a % 2 == 1); end
                    4'h6: begin r = (a * 2) % 256;              nc = (a >= 128); end
                    4'h7: begin r = (a * 2) % 256 + 1;          nc = (a >= 128); end
                    4'h4: begin r = (a * 2) % 256 + a % 2;      nc = (a >= 128); end
                    4'h0: begin r = (a * 2) % 256 + (m_c ? 1 : 0); nc = (a >= 128); end
                    4'h2: begin r = (a * 2) % 256 + (a >= 128 ? 1 : 0); nc = (a >= 128); end
                    default: legal = 0;
                endcase
            end
            default: legal = 0;
        endcase
        nz = (r == 0);
        if (legal && wr) m_regs[x] = 8'(r);
        if (rs) begin
            m_z = m_sh_z; m_c = m_sh_c;
        end else if (legal && upd) begin
            m_z = nz; m_c = nc;
        end
        if (sv) begin m_sh_z = oz; m_sh_c = oc; end
        e.ill = !legal; e.z = m_z; e.c = m_c;
        for (int i = 0; i < 16; i++) e.regs[i] = m_regs[i];
        sb.push_back(e);
    endtask

    // Offer one instruction; strobes are applied during its EXEC cycle, noise on the bus meanwhile.
    task automatic issue(input logic [17:0] ins, input bit sv, input bit rs);
        int unsigned t = 0;
        ibus.instr_valid = 1'b1;
        ibus.instr       = ins;
        @(negedge clk);
        while (!ibus.instr_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!ibus.instr_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout actual=ready_low required=ready_high instr=%h", ins);
            ibus.instr_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        model_step(ins, sv, rs);
        ibus.instr_valid = 1'($urandom);
        ibus.instr       = 18'($urandom);
        flags_save       = sv;
        flags_restore    = rs;
        @(posedge clk); #1;
        flags_save       = 1'b0;
        flags_restore    = 1'b0;
        ibus.instr_valid = 1'b0;
    endtask

    // Monitor: pops one expectation per done pulse and checks the retired state.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && done) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = sb.pop_front();
                    check("illegal", 32'(illegal), 32'(e.ill));
                    check("ready_in_exec", 32'(ibus.instr_ready), 32'd0);
                    @(negedge clk);
                    check("done_pulse", 32'(done), 32'd0);
                    check("illegal_clear", 32'(illegal), 32'd0);
                    check("flag_zero", 32'(flag_zero), 32'(e.z));
                    check("flag_carry", 32'(flag_carry), 32'(e.c));
                    for (int i = 0; i < 16; i++) begin
                        rf_addr = 4'(i);
                        #1;
                        check($sformatf("reg_s%0d", i), 32'(rf_data), 32'(e.regs[i]));
                    end
                end
            end
        end
    end

    logic [5:0]  legal_ops [21] = '{6'h00, 6'h01, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                                    6'h12, 6'h13, 6'h14, 6'h15, 6'h18, 6'h19, 6'h1A, 6'h1B,
                                    6'h1C, 6'h1D, 6'h1E, 6'h1F, 6'h20};
    logic [17:0] plan [10] = '{18'h0007F, 18'h18081, 18'h1B100, 18'h14102, 18'h20108,
                               18'h2010E, 18'h3F000, 18'h20105, 18'h005FF, 18'h18501};

    initial begin
        logic [5:0]  opc;
        int unsigned t;
        reset_n          = 1'b0;
        ibus.instr_valid = 1'b0;
        ibus.instr       = '0;
        flags_save       = 1'b0;
        flags_restore    = 1'b0;
        rf_addr          = '0;
        model_reset();
        #1;
        check("ready_during_reset", 32'(ibus.instr_ready), 32'd0);
        repeat (2) @(posedge clk);
        #10 reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(ibus.instr_ready), 32'd1);
        check("done_reset", 32'(done), 32'd0);
        check("illegal_reset", 32'(illegal), 32'd0);
        check("alu_ctrl_reset", {25'd0, alu_operation, alu_shift_operation},  32'd0);
        check("alu_operands_reset", {16'd0, alu_operand_a, alu_operand_b}, 32'd0);
        check("alu_bits_reset", {29'd0, alu_shift_direction, alu_shift_constant, alu_carry_in}, 32'd0);
        check("flags_reset", {30'd0, flag_zero, flag_carry}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            rf_addr = 4'(i);
            #1;
            check($sformatf("reset_s%0d", i), 32'(rf_data), 32'd0);
        end
        @(posedge clk); #1;

        foreach (plan[i]) issue(plan[i], 1'b0, 1'b0);
        issue(18'h18201, 1'b1, 1'b0);
        issue(18'h00600, 1'b0, 1'b1);
        issue(18'h0C202, 1'b1, 1'b1);

        // Abort LOAD s3,55 by reset in its EXEC cycle.
        ibus.instr_valid = 1'b1;
        ibus.instr       = 18'h00355;
        @(negedge clk);
        check("ready_before_abort", 32'(ibus.instr_ready), 32'd1);
        @(posedge clk); #1;
        ibus.instr_valid = 1'b0;
        reset_n          = 1'b0;
        @(negedge clk);
        check("ready_in_abort_reset", 32'(ibus.instr_ready), 32'd0);
        check("done_in_abort_reset", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        check("ready_after_abort", 32'(ibus.instr_ready), 32'd1);
        rf_addr = 4'd3;
        #1;
        check("aborted_s3", 32'(rf_data), 32'd0);
        check("flags_after_abort", {30'd0, flag_zero, flag_carry}, 32'd0);
        @(posedge clk); #1;

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(7) == 0) opc = 6'($urandom);
            else                        opc = legal_ops[$urandom_range(20)];
            issue({opc, 12'($urandom)}, ($urandom_range(5) == 0), ($urandom_range(5) == 0));
        end

        t = 0;
        while (sb.size() != 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain actual=%0d_pending required=0_pending", sb.size());
        end
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pacoblaze_alu_sequencer.md
Name: pacoblaze_alu_sequencer

Overview:
- Front-end that drives the PacoBlaze ALU: accepts 18-bit KCPSM3-format arithmetic/logic/shift instructions, reads operands from a 16x8 register file and drives the ALU control and operand inputs.
- Registers the ALU result, zero and carry back into the register file and the flags, with PicoBlaze two-cycle instruction timing.
- Sits between the instruction fetch/control path and the combinational ALU instance.

Parameters:
- NUM_REGS, 16, register file depth. Fixed by the 4-bit sX/sY fields.
- REG_WIDTH, 8, register and operand width. Must equal `operand_width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  instruction offered.
- instr  in  18  instruction word: [17:12] opcode, [11:8] sX, [7:4] sY, [7:0] kk.
- instr_ready  out  1  block can accept an instruction.
- alu_operation  out  `operation_width  ALU main operation, from the `op_* defines.
- alu_shift_operation  out  3  shift select (`opcode_rr/rl/rsa/rsc); equals instr[2:1] of the held shift instruction.
- alu_shift_direction  out  1  0 = left, 1 = right; equals held instr[3].
- alu_shift_constant  out  1  held instr[0].
- alu_operand_a  out  8  sX value.
- alu_operand_b  out  8  sY value or kk.
- alu_carry_in  out  1  current flag_carry.
- alu_result  in  8  ALU result.
- alu_zero  in  1  ALU zero out.
- alu_carry  in  1  ALU carry out.
- flag_zero  out  1  Z flag.
- flag_carry  out  1  C flag.
- flags_save  in  1  strobe: copy Z/C to shadow.
- flags_restore  in  1  strobe: copy shadow to Z/C.
- illegal  out  1  high during EXEC of an unsupported opcode.
- done  out  1  one-cycle pulse in EXEC (legal or illegal).
- rf_addr  in  4  debug read address.
- rf_data  out  8  combinational read of register rf_addr.

Behaviour:
- Reset: all 16 registers 0x00, Z = C = 0, shadow = 0, state IDLE, all alu_* outputs 0, illegal = done = 0. instr_ready is 0 while reset_n is low and 1 after release.
- States:
  - IDLE: instr_ready = 1. On instr_valid && instr_ready: latch instr, sample sX, and sample sY or kk (kk when opcode[0] = 0) into operand registers, then go to EXEC.
  - EXEC: instr_ready = 0, done = 1, ALU controls are driven from the latched values. At the end of EXEC: writeback, flag update, return to IDLE.
- Latency: accept at edge N, result visible on rf_data and flags after edge N+1, next accept at edge N+2. Throughput is one instruction per 2 cycles.
- Opcodes (opcode[0] = 1 selects sY):
  - LOAD 00/01: write operand_b to sX. Flags unchanged.
  - AND 0A/0B, OR 0C/0D, XOR 0E/0F: write result. Z = alu_zero, C = 0.
  - TEST 12/13: no write. Z = alu_zero, C = alu_carry (parity).
  - COMPARE 14/15: no write. Z and C from the ALU.
  - ADD 18/19, ADDCY 1A/1B, SUB 1C/1D, SUBCY 1E/1F: write result; Z and C from the ALU. ADDCY/SUBCY use flag_carry as sampled in EXEC.
  - Shift 20, sY and kk[7:4] ignored: write result, Z and C from the ALU. Low-nibble encodings:
    - SR0 E, SR1 F, SRX A, SRA 8, RR C
    - SL0 6, SL1 7, SLX 4, SLA 0, RL 2
- Any other opcode, or shift with instr[3:0] not listed above: illegal = 1 in EXEC, no register write, flags unchanged.
- Arithmetic is modulo 256. Carry/borrow semantics are those of the ALU, passed through unmodified.
- Flag priority in one cycle: flags_restore overrides the EXEC flag update. flags_save captures pre-update values. save + restore in the same cycle: restore uses the old shadow, and the shadow takes current Z/C.
- instr_valid held high during EXEC is ignored (no double accept). instr changing in EXEC has no effect.
- reset_n low mid-EXEC: instruction aborted, no writeback, all state returns to reset values.
- rf_data reflects a write the cycle after the EXEC edge.

Test Plan:
1. After reset, instr 0x0007F (LOAD s0,7F) -> instr_ready drops for 1 cycle, done pulses once, rf_data[s0] = 0x7F, Z = 0, C = 0.
2. Then 0x18081 (ADD s0,81) -> s0 = 0x00, Z = 1, C = 1.
3. Then 0x1B100 (ADDCY s1,s0) with s1 = 0 -> s1 = 0x01, Z = 0, C = 0. Then 0x14102 (COMPARE s1,02) -> s1 stays 0x01, C = 1, Z = 0.
4. C = 1, s1 = 0x01, instr 0x20108 (SRA s1) -> s1 = 0x80, C = 1, Z = 0. Then 0x2010E (SR0) -> s1 = 0x40, C = 0.
5. Instr 0x3F000 -> illegal high exactly in EXEC, all registers and flags unchanged. Instr 0x20105 -> illegal.
6. Z = 1, C = 1 with flags_save; ADD s2,01 from s2 = 0 (Z = 0, C = 0); flags_restore -> Z = 1, C = 1. Reset_n pulsed low during EXEC of LOAD s3,55 -> s3 = 0x00, instr_ready = 1 after release.
